// File: rtl/fir_transposed_cfg_if.sv
// Sample stream, coefficient-load bus and control strobes of the configurable FIR.
// The master modport belongs to the sample source and the slave modport to the filter.
interface fir_transposed_cfg_if #(
    parameter int DATA_W = 18,
    parameter int COEF_W = 18,
    parameter int OUT_W  = 24,
    parameter int ADDR_W = 3
);
    logic                     ena;
    logic                     clear;
    logic                     in_valid;
    logic signed [DATA_W-1:0] x_in;
    logic                     coef_we;
    logic [ADDR_W-1:0]        coef_addr;
    logic signed [COEF_W-1:0] coef_wdata;
    logic                     coef_commit;
    logic                     ovf_clr;
    logic                     out_valid;
    logic signed [OUT_W-1:0]  dout;
    logic                     ovf;

    modport master (
        output ena, clear, in_valid, x_in, coef_we, coef_addr, coef_wdata, coef_commit, ovf_clr,
        input  out_valid, dout, ovf
    );

    modport slave (
        input  ena, clear, in_valid, x_in, coef_we, coef_addr, coef_wdata, coef_commit, ovf_clr,
        output out_valid, dout, ovf
    );
endinterface

// File: rtl/fir_transposed_cfg.sv
// Transposed-form FIR with a shadow/active coefficient bank pair, a three-register
// pipeline (x capture, product/sum chain, output), round-half-up, saturation and a
// sticky overflow flag. ena freezes every register, including the coefficient banks.
module fir_transposed_cfg #(
    parameter int TAPS   = 5,
    parameter int DATA_W = 18,
    parameter int COEF_W = 18,
    parameter int OUT_W  = 24,
    parameter int SHIFT  = 0
) (
    input  logic               clk,
    input  logic               rst,
    fir_transposed_cfg_if.slave bus
);
    localparam int ACC_W  = DATA_W + COEF_W + $clog2(TAPS);
    localparam int PROD_W = DATA_W + COEF_W;
    localparam int ADDR_W = $clog2(TAPS);

    // Half an output LSB in accumulator units; zero when no shift is applied.
    localparam logic signed [ACC_W-1:0] RND_HALF = (ACC_W'(1) << SHIFT) >> 1;
    localparam logic signed [ACC_W-1:0] OUT_MAX  = (ACC_W'(1) << (OUT_W - 1)) - ACC_W'(1);
    localparam logic signed [ACC_W-1:0] OUT_MIN  = ~OUT_MAX;

    logic signed [DATA_W-1:0] x_q_reg;
    logic                     v1_reg;
    logic signed [ACC_W-1:0]  p_reg    [TAPS];
    logic signed [ACC_W-1:0]  p_next   [TAPS];
    logic signed [PROD_W-1:0] prod     [TAPS];
    logic signed [ACC_W-1:0]  prod_ext [TAPS];
    logic signed [COEF_W-1:0] shadow_reg [TAPS];
    logic signed [COEF_W-1:0] active_reg [TAPS];
    logic                     out_valid_reg;
    logic signed [OUT_W-1:0]  dout_reg;
    logic                     ovf_reg;
    logic signed [ACC_W-1:0]  rnd_val;
    logic signed [OUT_W-1:0]  sat_val;
    logic                     clamp;

    // Each tap multiplies the shared x register by its active coefficient; the chain
    // adds the product into the partial sum handed down from the next-higher tap.
    generate
        for (genvar gi = 0; gi < TAPS; gi++) begin : g_tap
            assign prod[gi]     = active_reg[gi] * x_q_reg;
            assign prod_ext[gi] = {{(ACC_W - PROD_W){prod[gi][PROD_W-1]}}, prod[gi]};
            if (gi == TAPS - 1) begin : g_last
                assign p_next[gi] = prod_ext[gi];
            end else begin : g_mid
                assign p_next[gi] = p_reg[gi+1] + prod_ext[gi];
            end
        end
    endgenerate

    // Round the value entering p[0] and clamp it to the output range.
    always_comb begin
        rnd_val = (p_next[0] + RND_HALF) >>> SHIFT;
        sat_val = rnd_val[OUT_W-1:0];
        clamp   = 1'b0;
        if (rnd_val > OUT_MAX) begin
            sat_val = OUT_MAX[OUT_W-1:0];
            clamp   = 1'b1;
        end else if (rnd_val < OUT_MIN) begin
            sat_val = OUT_MIN[OUT_W-1:0];
            clamp   = 1'b1;
        end
    end

    // Datapath pipeline: x capture, product/sum chain and output register; clear flushes it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            x_q_reg       <= '0;
            v1_reg        <= 1'b0;
            out_valid_reg <= 1'b0;
            dout_reg      <= '0;
            for (int k = 0; k < TAPS; k++) p_reg[k] <= '0;
        end else if (bus.ena) begin
            if (bus.clear) begin
                x_q_reg       <= '0;
                v1_reg        <= 1'b0;
                out_valid_reg <= 1'b0;
                for (int k = 0; k < TAPS; k++) p_reg[k] <= '0;
            end else begin
                if (bus.in_valid) x_q_reg <= bus.x_in;
                v1_reg        <= bus.in_valid;
                out_valid_reg <= v1_reg;
                if (v1_reg) begin
                    p_reg    <= p_next;
                    dout_reg <= sat_val;
                end
            end
        end
    end

    // Sticky overflow: a clamp on an output update wins over a simultaneous clear request.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ovf_reg <= 1'b0;
        end else if (bus.ena) begin
            if (v1_reg && !bus.clear && clamp) ovf_reg <= 1'b1;
            else if (bus.ovf_clr)              ovf_reg <= 1'b0;
        end
    end

    // Coefficient banks: commit copies the pre-write shadow, writes land in shadow only.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < TAPS; k++) begin
                shadow_reg[k] <= '0;
                active_reg[k] <= '0;
            end
        end else if (bus.ena) begin
            if (bus.coef_commit) active_reg <= shadow_reg;
            if (bus.coef_we && (int'(bus.coef_addr) < TAPS))
                shadow_reg[bus.coef_addr[ADDR_W-1:0]] <= bus.coef_wdata;
        end
    end

    assign bus.out_valid = out_valid_reg;
    assign bus.dout      = dout_reg;
    assign bus.ovf       = ovf_reg;
endmodule

// File: tb/tb_fir_transposed_cfg.sv
// Bench for fir_transposed_cfg: two instances (no shift / shift 2, both 16-bit output)
// share one stimulus stream. The reference keeps, per accepted sample, the sample and
// the coefficient bank it was multiplied with, and forms y[n] as a plain sum.
module tb_fir_transposed_cfg;
    localparam int TAPS = 5;
    localparam int DW   = 18;
    localparam int CW   = 18;
    localparam int OW   = 16;
    localparam int AW   = 3;
    localparam int SHF[2] = '{0, 2};

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic                 ena, clear, in_valid, coef_we, coef_commit, ovf_clr;
    logic signed [DW-1:0] x_in;
    logic [AW-1:0]        coef_addr;
    logic signed [CW-1:0] coef_wdata;

    fir_transposed_cfg_if #(.DATA_W(DW), .COEF_W(CW), .OUT_W(OW), .ADDR_W(AW)) bus0 ();
    fir_transposed_cfg_if #(.DATA_W(DW), .COEF_W(CW), .OUT_W(OW), .ADDR_W(AW)) bus2 ();

    assign bus0.ena = ena;             assign bus2.ena = ena;
    assign bus0.clear = clear;         assign bus2.clear = clear;
    assign bus0.in_valid = in_valid;   assign bus2.in_valid = in_valid;
    assign bus0.x_in = x_in;           assign bus2.x_in = x_in;
    assign bus0.coef_we = coef_we;     assign bus2.coef_we = coef_we;
    assign bus0.coef_addr = coef_addr; assign bus2.coef_addr = coef_addr;
    assign bus0.coef_wdata = coef_wdata;   assign bus2.coef_wdata = coef_wdata;
    assign bus0.coef_commit = coef_commit; assign bus2.coef_commit = coef_commit;
    assign bus0.ovf_clr = ovf_clr;     assign bus2.ovf_clr = ovf_clr;

    fir_transposed_cfg #(.TAPS(TAPS), .DATA_W(DW), .COEF_W(CW), .OUT_W(OW), .SHIFT(0))
        u_dut0 (.clk(clk), .rst(rst), .bus(bus0));
    fir_transposed_cfg #(.TAPS(TAPS), .DATA_W(DW), .COEF_W(CW), .OUT_W(OW), .SHIFT(2))
        u_dut2 (.clk(clk), .rst(rst), .bus(bus2));

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input longint obs, input longint exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %0d, expected %0d", tag, $time, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    longint m_shadow [TAPS];
    longint m_active [TAPS];
    longint h_x [TAPS];          // h_x[j]: j-th most recent sample through the multiply stage
    longint h_c [TAPS][TAPS];    // bank that sample was multiplied with
    longint m_xq;
    bit     m_v1, m_ov;
    longint m_dout [2];
    bit     m_ovf [2];

    function automatic void model_reset();
        for (int k = 0; k < TAPS; k++) begin
            m_shadow[k] = 0; m_active[k] = 0; h_x[k] = 0;
            for (int j = 0; j < TAPS; j++) h_c[k][j] = 0;
        end
        m_xq = 0; m_v1 = 0; m_ov = 0;
        for (int s = 0; s < 2; s++) begin m_dout[s] = 0; m_ovf[s] = 0; end
    endfunction

    function automatic void model_step();
        longint old_active [TAPS];
        longint y, r, lim_hi, lim_lo;
        if (!ena) return;
        old_active = m_active;
        if (coef_commit) m_active = m_shadow;
        if (coef_we && int'(coef_addr) < TAPS) m_shadow[coef_addr] = longint'(coef_wdata);
        for (int s = 0; s < 2; s++) if (ovf_clr) m_ovf[s] = 0;
        if (clear) begin
            m_xq = 0; m_v1 = 0; m_ov = 0;
            for (int k = 0; k < TAPS; k++) h_x[k] = 0;
        end else begin
            if (m_v1) begin
                for (int j = TAPS - 1; j > 0; j--) begin
                    h_x[j] = h_x[j-1];
                    for (int k = 0; k < TAPS; k++) h_c[j][k] = h_c[j-1][k];
                end
                h_x[0] = m_xq;
                for (int k = 0; k < TAPS; k++) h_c[0][k] = old_active[k];
                y = 0;
                for (int j = 0; j < TAPS; j++) y += h_c[j][j] * h_x[j];
                lim_hi = (longint'(1) << (OW - 1)) - 1;
                lim_lo = -(longint'(1) << (OW - 1));
                for (int s = 0; s < 2; s++) begin
                    r = (SHF[s] == 0) ? y : ((y + (longint'(1) << (SHF[s] - 1))) >>> SHF[s]);
                    if (r > lim_hi)      begin r = lim_hi; m_ovf[s] = 1; end
                    else if (r < lim_lo) begin r = lim_lo; m_ovf[s] = 1; end
                    m_dout[s] = r;
                end
            end
            m_ov = m_v1;
            if (in_valid) m_xq = longint'(x_in);
            m_v1 = in_valid;
        end
    endfunction

    task automatic compare_all();
        chk("out_valid0", longint'(bus0.out_valid), longint'(m_ov));
        chk("out_valid2", longint'(bus2.out_valid), longint'(m_ov));
        chk("dout0", longint'(bus0.dout), m_dout[0]);
        chk("dout2", longint'(bus2.dout), m_dout[1]);
        chk("ovf0", longint'(bus0.ovf), longint'(m_ovf[0]));
        chk("ovf2", longint'(bus2.ovf), longint'(m_ovf[1]));
        if (bus0.out_valid && ena)
            $display("t=%0t out dout0=%0d dout2=%0d ovf0=%0b ovf2=%0b",
                     $time, bus0.dout, bus2.dout, bus0.ovf, bus2.ovf);
    endtask

    // Inputs are driven at the falling edge; outputs are checked at the next falling edge.
    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_all();
    endtask

    task automatic idle();
        ena = 1; clear = 0; in_valid = 0; x_in = '0; coef_we = 0;
        coef_addr = '0; coef_wdata = '0; coef_commit = 0; ovf_clr = 0;
    endtask

    int bank [TAPS];
    task automatic load_bank();
        for (int k = 0; k < TAPS; k++) begin
            coef_we = 1; coef_addr = AW'(k); coef_wdata = CW'(bank[k]);
            cycle();
        end
        coef_we = 0; coef_commit = 1;
        cycle();
        coef_commit = 0;
    endtask

    task automatic do_clear();
        clear = 1; cycle(); clear = 0;
    endtask

    // Feed xs back to back, then drain; each result on the selected instance is
    // checked against the hand-derived constants queued in exp_q.
    int xs[$];
    int exp_q[$];
    task automatic run_seq(input string tag, input bit use_shift2);
        int n = xs.size() + 4;
        for (int i = 0; i < n; i++) begin
            in_valid = (i < xs.size());
            x_in = (i < xs.size()) ? DW'(xs[i]) : '0;
            cycle();
            if ((use_shift2 ? bus2.out_valid : bus0.out_valid) && exp_q.size() > 0)
                chk(tag, use_shift2 ? longint'(bus2.dout) : longint'(bus0.dout),
                    longint'(exp_q.pop_front()));
        end
        in_valid = 0;
        chk({tag, "_count"}, longint'(exp_q.size()), 0);
        exp_q.delete();
        xs.delete();
    endtask

    initial begin
        idle();
        model_reset();
        rst = 0;
        repeat (2) @(negedge clk);
        compare_all();
        rst = 1;
        cycle();

        // Impulse response; latency: no output on the edge right after the accept.
        bank = '{200, 152, 48, -30, -37};
        load_bank();
        in_valid = 1; x_in = 18'sd1;
        cycle();
        chk("latency", longint'(bus0.out_valid), 0);
        xs = '{0, 0, 0, 0, 0};
        exp_q = '{200, 152, 48, -30, -37, 0};
        run_seq("impulse", 1'b0);

        // Rounding on the shift-2 instance.
        do_clear();
        bank = '{1, 0, 0, 0, 0};
        load_bank();
        xs = '{6, -6, 5, -5};
        exp_q = '{2, -1, 1, -1};
        run_seq("round", 1'b1);

        // Saturation and sticky overflow.
        do_clear();
        ovf_clr = 1; cycle(); ovf_clr = 0;
        bank = '{131071, 0, 0, 0, 0};
        load_bank();
        xs = '{131071, -131072};
        exp_q = '{32767, -32768};
        run_seq("sat", 1'b0);
        chk("ovf_set", longint'(bus0.ovf), 1);
        ovf_clr = 1; cycle(); ovf_clr = 0;
        chk("ovf_clr", longint'(bus0.ovf), 0);
        in_valid = 1; x_in = 18'sd131071; cycle();
        in_valid = 0; ovf_clr = 1; cycle(); ovf_clr = 0;
        chk("ovf_set_wins", longint'(bus0.ovf), 1);
        ovf_clr = 1; cycle(); ovf_clr = 0;

        // Commit boundary: bank A all 1, then bank B all 2 committed mid-stream.
        do_clear();
        bank = '{1, 1, 1, 1, 1};
        load_bank();
        in_valid = 1; x_in = 18'sd10;
        repeat (8) cycle();
        chk("bank_a", longint'(bus0.dout), 50);
        for (int k = 0; k < TAPS; k++) begin
            coef_we = 1; coef_addr = AW'(k); coef_wdata = 18'sd2; cycle();
        end
        coef_we = 0; coef_commit = 1; cycle(); coef_commit = 0;
        repeat (8) cycle();
        chk("bank_b", longint'(bus0.dout), 100);
        in_valid = 0;

        // Clear during an impulse tail leaves no residue.
        bank = '{200, 152, 48, -30, -37};
        load_bank();
        do_clear();
        in_valid = 1; x_in = 18'sd1; cycle();
        in_valid = 1; x_in = 18'sd0; repeat (3) cycle();
        do_clear();
        chk("clear_ov", longint'(bus0.out_valid), 0);
        in_valid = 1; x_in = 18'sd0; cycle(); cycle();
        chk("clear_residue", longint'(bus0.dout), 0);
        in_valid = 0;

        // Randomised traffic: stalls, gaps, loads, commits, clears, overflow clears.
        for (int i = 0; i < 1500; i++) begin
            logic signed [DW-1:0] xr;
            logic signed [CW-1:0] cr;
            ena      = ($urandom_range(7) != 0);
            in_valid = ($urandom_range(3) != 0);
            xr = DW'($urandom);
            x_in = ($urandom_range(3) == 0) ? xr : DW'(int'($urandom_range(600)) - 300);
            coef_we = ($urandom_range(5) == 0);
            coef_addr = AW'($urandom_range(7));
            cr = CW'($urandom);
            coef_wdata = ($urandom_range(3) == 0) ? cr : CW'(int'($urandom_range(1000)) - 500);
            coef_commit = ($urandom_range(19) == 0);
            clear   = (!coef_we && !coef_commit && $urandom_range(39) == 0);
            ovf_clr = (!clear && $urandom_range(9) == 0);
            cycle();
            if (i == 900) begin
                // Asynchronous reset mid-stream: outputs drop without waiting for an edge.
                #2 rst = 0;
                #1;
                model_reset();
                compare_all();
                chk("rst_dout", longint'(bus0.dout), 0);
                @(negedge clk);
                rst = 1;
                idle();
                in_valid = 1; x_in = 18'sd1000;
                repeat (4) cycle();
                chk("rst_no_coef", longint'(bus0.dout), 0);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
